program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter WORDS, default 128: payload words per load, legal range 1..128.
REQ-002 Parameter BASE_ADDR, default 8'h00: byte address of the first word; bit 0 SHALL be 0.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  load request, sampled on each posedge.
REQ-006 in_valid  input  1  source has a word on in_data.
REQ-007 in_data  input  16  program word from the source.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 mem_we  output  1  memory write enable, same bus the CPU drives.
REQ-010 mem_addr  output  8  byte address; the memory uses mem_addr[7:1].
REQ-011 mem_in  output  16  write data to memory.
REQ-012 cpu_hold  output  1  high means CPU is held in reset and off the memory bus.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  level, last load finished.
REQ-015 err  output  1  checksum mismatch on last load.

Function
REQ-016 FSM states are IDLE, LOAD, CHECK (macro only) and DONE; all outputs are registered.
REQ-017 IDLE or DONE with start=1 -> LOAD; cpu_hold=1, done=0, err=0, busy=1, word index=0.
REQ-018 start while busy is ignored, with no restart and no index change.
REQ-019 In LOAD, in_ready=1; a transfer is in_valid&&in_ready at a posedge; in_ready=0 in every other state.
REQ-020 Each transfer produces exactly one write in the next cycle: mem_we=1, mem_in=word, mem_addr=(BASE_ADDR+2*index) mod 256.
REQ-021 mem_we=0 in every cycle without a pending write; mem_addr and mem_in hold their last values.
REQ-022 Throughput is one word per cycle; in_valid gaps insert idle cycles with no write.
REQ-023 Address wraps modulo 256, e.g. BASE_ADDR=8'hFC with word 2 -> 8'h00.
REQ-024 After transfer number WORDS, without the macro: the final write occurs, then DONE on the following cycle with done=1, busy=0, cpu_hold=0.
REQ-025 In DONE, cpu_hold stays 0 until the next start or reset.

Reset
REQ-026 rst_n=0 at a posedge -> IDLE, mem_we=0, in_ready=0, busy=0, done=0, err=0, cpu_hold=1, index=0, sum=0, mem_addr=0, mem_in=0.
REQ-027 Reset mid-load aborts with no further write; written words stay in memory; cpu_hold stays 1 until a later load completes.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: a 16-bit wrapping sum of payload words is kept; after transfer WORDS the FSM enters CHECK, which keeps in_ready=1.
REQ-029 The CHECK transfer is the checksum word and is not written; mismatch -> err=1, otherwise err=0.
REQ-030 With the macro, the FSM then enters DONE with done=1 and busy=0; cpu_hold=0 only if err=0.
REQ-031 Macro undefined: no CHECK state, no sum logic, err tied 0, behaviour per REQ-024.

Verification
REQ-032 WORDS=5, BASE=0, start, stream F104,F201,5312,F207,5312 back-to-back -> writes at 00,02,04,06,08 with that data on consecutive cycles; done=1 and cpu_hold=0 one cycle after the last write.
REQ-033 Same data with in_valid low 3 cycles between words -> identical writes, no mem_we during gaps, done after the fifth write.
REQ-034 WORDS=4, BASE=8'hFC, data 1,2,3,4 -> mem_addr FC,FE,00,02.
REQ-035 LOADER_CHECKSUM_EN, REQ-032 data plus 7B30 -> err=0, cpu_hold=0; plus 7B31 instead -> err=1, done=1, cpu_hold=1, and 7B3x is never written.
REQ-036 rst_n low for 1 cycle after 2 of 5 words -> only 00 and 02 written, IDLE with cpu_hold=1; new start reloads from 00.
REQ-037 start pulsed during LOAD after word 1 -> ignored; the sequence completes with 5 writes.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: streams WORDS program words from a source into CPU memory while
// holding the CPU in reset. Optional checksum word verification under LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int         WORDS     = 128,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_in,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: a word moves when in_valid && in_ready are both high at a posedge;
  // the source must hold in_data stable while in_valid is high and in_ready is low.

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

  state_t     state;
  logic [7:0] idx;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= 8'd0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 8'd0;
      mem_in   <= 16'd0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= 16'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          // busy still high in DONE means this is the cycle after the final
          // write or the checksum compare; completion is published here.
          if (state == S_DONE && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            cpu_hold <= err_q;
`else
            cpu_hold <= 1'b0;
`endif
          end else if (start) begin
            state    <= S_LOAD;
            idx      <= 8'd0;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= 16'd0;
            err_q    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            mem_we   <= 1'b1;
            mem_in   <= in_data;
            mem_addr <= BASE_ADDR + {idx[6:0], 1'b0};
            idx      <= idx + 8'd1;
`ifdef LOADER_CHECKSUM_EN
            sum      <= sum + in_data;
            if (idx == LAST_IDX) state <= S_CHECK;
`else
            if (idx == LAST_IDX) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          // The checksum word is compared, never written to memory.
          if (in_valid) begin
            err_q    <= (in_data != sum);
            in_ready <= 1'b0;
            state    <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 5-word instance at base 00 and a 4-word
// instance at base FC. Define LOADER_CHECKSUM_EN for both RTL and bench to test checksum mode.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_valid, a_ready, a_we, a_hold, a_busy, a_done, a_err;
  logic [15:0] a_data, a_min;
  logic [7:0]  a_addr;
  logic [1:0]  a_state;

  logic        b_start, b_valid, b_ready, b_we, b_hold, b_busy, b_done, b_err;
  logic [15:0] b_data, b_min;
  logic [7:0]  b_addr;
  logic [1:0]  b_state;

  program_loader #(.WORDS(5), .BASE_ADDR(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr), .mem_in(a_min),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done), .err(a_err), .state_dbg(a_state)
  );

  program_loader #(.WORDS(4), .BASE_ADDR(8'hFC)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr), .mem_in(b_min),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .err(b_err), .state_dbg(b_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dat [5] = '{16'hF104, 16'hF201, 16'h5312, 16'hF207, 16'h5312};
  logic [7:0]  adr [5] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08};
  logic [7:0]  badr [4] = '{8'hFC, 8'hFE, 8'h00, 8'h02};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_begin;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    chk("a_start_ready", a_ready, 1);
    chk("a_start_busy", a_busy, 1);
    chk("a_start_hold", a_hold, 1);
    chk("a_start_done", a_done, 0);
    chk("a_start_err", a_err, 0);
  endtask

  task automatic a_word(input logic [15:0] d, input logic [7:0] addr);
    a_valid = 1'b1;
    a_data  = d;
    tick;
    chk("a_we", a_we, 1);
    chk("a_addr", a_addr, addr);
    chk("a_wdata", a_min, d);
  endtask

  task automatic a_gap(input int n);
    a_valid = 1'b0;
    repeat (n) begin
      tick;
      chk("a_gap_we", a_we, 0);
    end
  endtask

  task automatic a_finish(input logic [15:0] cks, input logic exp_err);
`ifdef LOADER_CHECKSUM_EN
    a_valid = 1'b1;
    a_data  = cks;
    tick;
    chk("a_cks_we", a_we, 0);
    chk("a_cks_done", a_done, 0);
    a_valid = 1'b0;
    tick;
    chk("a_fin_done", a_done, 1);
    chk("a_fin_busy", a_busy, 0);
    chk("a_fin_err", a_err, exp_err);
    chk("a_fin_hold", a_hold, exp_err);
    chk("a_fin_we", a_we, 0);
    chk("a_fin_ready", a_ready, 0);
`else
    a_valid = 1'b0;
    a_data  = cks;
    tick;
    chk("a_fin_done", a_done, 1);
    chk("a_fin_busy", a_busy, 0);
    chk("a_fin_err", a_err, 0);
    chk("a_fin_hold", a_hold, 0);
    chk("a_fin_we", a_we, 0);
    chk("a_fin_ready", a_ready, 0);
    chk("a_fin_noerr", {15'd0, exp_err}, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_data = 16'h0;
    b_start = 1'b0; b_valid = 1'b0; b_data = 16'h0;
    tick;
    tick;
    chk("rst_we", a_we, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_hold", a_hold, 1);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_min, 0);
    chk("rst_b_hold", b_hold, 1);
    rst_n = 1'b1;
    tick;
    chk("idle_ready", a_ready, 0);

    // Back-to-back stream
    a_begin;
    for (int i = 0; i < 5; i++) a_word(dat[i], adr[i]);
    a_finish(16'h7B30, 1'b0);
    tick;
    chk("done_hold_stays", a_hold, 0);
    chk("done_level", a_done, 1);
    chk("addr_holds", a_addr, 8'h08);
    chk("wdata_holds", a_min, 16'h5312);

    // Three idle cycles between words
    a_begin;
    for (int i = 0; i < 5; i++) begin
      a_word(dat[i], adr[i]);
      if (i < 4) a_gap(3);
    end
    a_finish(16'h7B30, 1'b0);

    // start pulsed mid-load is ignored
    a_begin;
    a_word(dat[0], adr[0]);
    a_start = 1'b1;
    a_word(dat[1], adr[1]);
    a_start = 1'b0;
    chk("restart_busy", a_busy, 1);
    for (int i = 2; i < 5; i++) a_word(dat[i], adr[i]);
    a_finish(16'h7B30, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum keeps CPU held
    a_begin;
    for (int i = 0; i < 5; i++) a_word(dat[i], adr[i]);
    a_finish(16'h7B31, 1'b1);
    tick;
    chk("bad_hold_stays", a_hold, 1);
    chk("bad_addr_unwritten", a_addr, 8'h08);
`endif

    // Reset after two words aborts the load
    a_begin;
    a_word(dat[0], adr[0]);
    a_word(dat[1], adr[1]);
    rst_n   = 1'b0;
    a_valid = 1'b1;
    a_data  = dat[2];
    tick;
    chk("abort_we", a_we, 0);
    chk("abort_ready", a_ready, 0);
    chk("abort_hold", a_hold, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    rst_n   = 1'b1;
    a_valid = 1'b0;
    tick;
    chk("abort_idle_we", a_we, 0);
    chk("abort_idle_hold", a_hold, 1);
    a_begin;
    for (int i = 0; i < 5; i++) a_word(dat[i], adr[i]);
    a_finish(16'h7B30, 1'b0);

    // Address wrap at base FC
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("b_start_ready", b_ready, 1);
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_data  = 16'(i + 1);
      tick;
      chk("b_we", b_we, 1);
      chk("b_addr", b_addr, badr[i]);
      chk("b_wdata", b_min, 16'(i + 1));
    end
`ifdef LOADER_CHECKSUM_EN
    b_data = 16'h000A;
    tick;
    chk("b_cks_we", b_we, 0);
`endif
    b_valid = 1'b0;
    tick;
    chk("b_done", b_done, 1);
    chk("b_hold", b_hold, 0);
    chk("b_busy", b_busy, 0);
    chk("b_err", b_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
